apb_timer: RTL and testbench
============================

# apb_timer

Memory-mapped machine timer on the CPU's APB bus: a 64-bit free-running counter with a 64-bit compare register and a sticky pending flag. It is an APB slave downstream of the CPU's APB master port and drives the CPU's `interrupt` input. Mapped above 0x1000 (system space); upstream decode drives `APB_psel`.

## Interface
- `ADDR_WIDTH`, 32, APB address width.
- `DATA_WIDTH`, 32, APB data width; only 32 is supported.
- `WAIT_STATES`, 0, extra ACCESS cycles before `APB_pready` (0–15).
- `APB_PCLK`  in  1  sole clock; all state on its rising edge.
- `APB_PRESETn`  in  1  asynchronous, active-low reset.
- `APB_paddr`  in  ADDR_WIDTH  byte address; only bits [7:0] are decoded.
- `APB_pdata`  in  DATA_WIDTH  write data.
- `APB_prdata`  out  DATA_WIDTH  read data; valid while `APB_pready` is high.
- `APB_psel`  in  1  slave select.
- `APB_penable`  in  1  ACCESS phase.
- `APB_pwrite`  in  1  1 = write.
- `APB_pstb`  in  4  write byte strobes; ignored on reads.
- `APB_pready`  out  1  transfer complete.
- `APB_perr`  out  1  slave error, qualified by `APB_pready`.
- `interrupt`  out  1  level output: `pending & CTRL.irq_en`.

## Operation
- Register map (offset):
  - 0x00 MTIME_LO rw.
  - 0x04 MTIME_HI rw.
  - 0x08 CMP_LO rw.
  - 0x0C CMP_HI rw.
  - 0x10 CTRL rw: [0] en, [1] irq_en, [15:8] prescale, other bits read 0.
  - 0x14 STATUS: [0] pending, write 1 to clear.
- Any other offset, or `APB_paddr[1:0]` != 0:
  - `APB_perr`=1 with `APB_pready`; the write is dropped; `APB_prdata`=0.
- Counting: when en=1, a prescale counter counts 0..prescale; MTIME increments by 1 on the cycle it wraps.
  - prescale=0 means MTIME increments every cycle.
  - MTIME wraps from 2^64-1 to 0. The prescale counter is held at 0 while en=0.
- Compare: on each cycle after an update, if MTIME >= CMP (unsigned, 64-bit), pending is set to 1.
  - pending is sticky; only a STATUS write-1 clears it.
  - Set and clear in the same cycle: set wins.
- Coherent read: reading MTIME_LO snapshots MTIME[63:32] into a shadow register; reading MTIME_HI returns the shadow, not live bits.
- Writes: `APB_pstb[i]` enables byte i.
  - A write to MTIME_LO/HI replaces those bits, and MTIME does not increment in the commit cycle (the write wins).
  - Writing CTRL.prescale resets the prescale counter.

## Timing
- Reset values:
  - MTIME=0, CMP=all ones, CTRL=0, pending=0, shadow=0, prescale counter=0.
  - `APB_pready`=0, `APB_perr`=0, `APB_prdata`=0, `interrupt`=0.
- FSM, IDLE / ACCESS:
  - IDLE→ACCESS on `APB_psel & !APB_penable` (setup); the wait counter loads `WAIT_STATES`.
  - In ACCESS, the wait counter decrements each cycle. `APB_pready` is registered and is high in the cycle the counter is 0.
  - With `WAIT_STATES`=0, `APB_pready` is high in the first ACCESS cycle.
- Commit: on the rising edge where `APB_psel & APB_penable & APB_pready`. Read side effects (shadow capture) and write effects are visible from the next cycle.
  - The FSM then returns to IDLE; `APB_pready`/`APB_perr` drop; `APB_prdata` returns to 0.
- Back-to-back transfers: a new setup in the cycle after commit is accepted, so a transfer takes 2+`WAIT_STATES` cycles.
- `APB_psel` deasserted during ACCESS (protocol violation): abort to IDLE with no side effects and no `APB_pready`.
- `interrupt` is registered and updates one cycle after pending/irq_en change.
- Asynchronous reset mid-transfer: all outputs go to their reset values immediately, and the FSM returns to IDLE.

## Structure
- Shared header `sys.v`, extended with:
  - the register offsets `TMR_MTIME_LO`…`TMR_STATUS`;
  - the CTRL bit positions and prescale field range;
  - the FSM state encodings.
- Sub-module `apb_slave_fsm` owns the IDLE/ACCESS FSM, wait counter, `APB_pready`, and commit/abort strobes. It is reusable for later APB peripherals.
- The top level holds the register file, prescaler, 64-bit counter, comparator and interrupt logic.

## Test plan
- Reset, then read every register: 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0; `interrupt`=0; each transfer `APB_pready` after 2 cycles (`WAIT_STATES`=0).
- Write CMP=10 (HI=0), CTRL=0x3 → MTIME counts 1/cycle; pending and `interrupt` go to 1 when MTIME reaches 10.
  - Write STATUS=1 while MTIME<CMP: `interrupt` goes to 0. Write STATUS=1 while MTIME>=CMP: it stays 1.
- CTRL=0x0301 (prescale 3) → MTIME increments every 4 cycles; write MTIME_LO=0xFFFFFFFF, HI=0xFFFFFFFF → it wraps to 0 after 4 cycles.
- Write MTIME_HI=0x5 with `APB_pstb`=0b0001, then read HI → 0x5; then write CMP_LO=0xAABBCCDD with `APB_pstb`=0b0110 → only bytes 1–2 change (CMP_LO reads 0xFFBBCCFF).
- Read 0x18 and 0x02 → `APB_perr`=1, `APB_prdata`=0, no state change; with `WAIT_STATES`=3, `APB_pready` appears in the 4th ACCESS cycle.
- Coherence: MTIME=0x00000000_FFFFFFFE counting; read LO then HI → HI=0 even after the carry; `APB_psel` dropped mid-ACCESS → no write; async reset mid-transfer → all outputs 0 immediately.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB machine timer: register offsets, CTRL field
// positions, slave FSM state encoding and a byte-strobe merge helper.
package apb_timer_pkg;

  localparam logic [7:0] TMR_MTIME_LO = 8'h00;
  localparam logic [7:0] TMR_MTIME_HI = 8'h04;
  localparam logic [7:0] TMR_CMP_LO   = 8'h08;
  localparam logic [7:0] TMR_CMP_HI   = 8'h0C;
  localparam logic [7:0] TMR_CTRL     = 8'h10;
  localparam logic [7:0] TMR_STATUS   = 8'h14;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PSC_LSB = 8;
  localparam int CTRL_PSC_MSB = 15;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// Reusable APB slave handshake: IDLE/ACCESS sequencing, wait-state down-counter,
// registered pready and single-cycle commit/abort strobes.
//
// state     | meaning
// ST_IDLE   | no transfer in progress, waiting for a setup phase
// ST_ACCESS | transfer selected; counting wait states, then pready until commit
module apb_slave_fsm
  import apb_timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic psel_i,
  input  logic penable_i,
  output logic pready_o,
  output logic commit_o,
  output logic abort_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       pready_q, pready_d;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    pready_d = pready_q;
    commit_o = 1'b0;
    abort_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d  = ST_ACCESS;
          wait_d   = WAIT_INIT;
          pready_d = (WAIT_INIT == 4'd0);
        end
      end
      ST_ACCESS: begin
        // Losing psel mid-transfer drops the transfer without a commit.
        if (!psel_i) begin
          abort_o  = 1'b1;
          state_d  = ST_IDLE;
          wait_d   = 4'd0;
          pready_d = 1'b0;
        end else if (penable_i && pready_q) begin
          commit_o = 1'b1;
          state_d  = ST_IDLE;
          pready_d = 1'b0;
        end else if (wait_q != 4'd0) begin
          wait_d   = wait_q - 4'd1;
          pready_d = (wait_q == 4'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      wait_q   <= 4'd0;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      pready_q <= pready_d;
    end
  end

  assign pready_o = pready_q;

endmodule

// File: rtl/apb_timer.sv
// APB machine timer: 64-bit prescaled counter, 64-bit compare, sticky pending
// flag with level interrupt, and a shadowed MTIME_HI for coherent 64-bit reads.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESETn,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  interrupt
);

  logic        commit, abort_unused;
  logic [7:0]  offs;
  logic        addr_ok, wr_commit, rd_commit, tick;
  logic        unused_addr;

  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  psc_q, psc_d, pcnt_q, pcnt_d;
  logic        en_q, en_d, irq_en_q, irq_en_d;
  logic        pending_q, pending_d, irq_q;

  apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk_i     (APB_PCLK),
    .rst_ni    (APB_PRESETn),
    .psel_i    (APB_psel),
    .penable_i (APB_penable),
    .pready_o  (APB_pready),
    .commit_o  (commit),
    .abort_o   (abort_unused)
  );

  assign unused_addr = ^APB_paddr[ADDR_WIDTH-1:8];
  assign offs        = APB_paddr[7:0];
  assign addr_ok     = (offs[1:0] == 2'b00) && (offs <= TMR_STATUS);
  assign wr_commit   = commit && APB_pwrite && addr_ok;
  assign rd_commit   = commit && !APB_pwrite && addr_ok;

  always_comb begin
    pcnt_d    = pcnt_q;
    tick      = 1'b0;
    cmp_d     = cmp_q;
    shadow_d  = shadow_q;
    psc_d     = psc_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;

    if (en_q) begin
      if (pcnt_q == psc_q) begin
        pcnt_d = 8'd0;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end else begin
      pcnt_d = 8'd0;
    end
    mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;

    if (wr_commit) begin
      case (offs)
        TMR_MTIME_LO: mtime_d = {mtime_q[63:32], apply_strb(mtime_q[31:0], APB_pdata, APB_pstb)};
        TMR_MTIME_HI: mtime_d = {apply_strb(mtime_q[63:32], APB_pdata, APB_pstb), mtime_q[31:0]};
        TMR_CMP_LO:   cmp_d   = {cmp_q[63:32], apply_strb(cmp_q[31:0], APB_pdata, APB_pstb)};
        TMR_CMP_HI:   cmp_d   = {apply_strb(cmp_q[63:32], APB_pdata, APB_pstb), cmp_q[31:0]};
        TMR_CTRL: begin
          if (APB_pstb[0]) begin
            en_d     = APB_pdata[CTRL_EN];
            irq_en_d = APB_pdata[CTRL_IRQ_EN];
          end
          if (APB_pstb[1]) begin
            psc_d  = APB_pdata[CTRL_PSC_MSB:CTRL_PSC_LSB];
            pcnt_d = 8'd0;
          end
        end
        TMR_STATUS: if (APB_pstb[0] && APB_pdata[0]) pending_d = 1'b0;
        default: ;
      endcase
    end

    if (rd_commit && offs == TMR_MTIME_LO) shadow_d = mtime_q[63:32];

    // Applied after the clear so a simultaneous set wins.
    if (mtime_q >= cmp_q) pending_d = 1'b1;
  end

  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      mtime_q   <= 64'd0;
      cmp_q     <= '1;
      shadow_q  <= 32'd0;
      psc_q     <= 8'd0;
      pcnt_q    <= 8'd0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      shadow_q  <= shadow_d;
      psc_q     <= psc_d;
      pcnt_q    <= pcnt_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      irq_q     <= pending_q & irq_en_q;
    end
  end

  // Read data is driven straight from registers while pready is up, so the LO
  // value returned matches the HI half captured into the shadow at commit.
  always_comb begin
    APB_prdata = '0;
    if (APB_pready && addr_ok && !APB_pwrite) begin
      case (offs)
        TMR_MTIME_LO: APB_prdata = mtime_q[31:0];
        TMR_MTIME_HI: APB_prdata = shadow_q;
        TMR_CMP_LO:   APB_prdata = cmp_q[31:0];
        TMR_CMP_HI:   APB_prdata = cmp_q[63:32];
        TMR_CTRL:     APB_prdata = {16'h0, psc_q, 6'h0, irq_en_q, en_q};
        TMR_STATUS:   APB_prdata = {31'h0, pending_q};
        default:      APB_prdata = '0;
      endcase
    end
  end

  assign APB_perr  = APB_pready && !addr_ok;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: one instance with no wait states, one with three,
// expectations queued at setup and checked when the slave signals pready.
module tb_apb_timer;

  localparam logic [31:0] B = 32'h0000_1000;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          chk;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pdata;
  logic        psel, penable, pwrite, use_ws;
  logic [3:0]  pstb;
  logic        psel0, psel1;
  logic [31:0] prdata0, prdata1, prdata;
  logic        pready0, pready1, perr0, perr1, irq0, irq1;
  logic        pready, perr;

  always #5 clk = ~clk;

  assign psel0  = psel & ~use_ws;
  assign psel1  = psel & use_ws;
  assign pready = use_ws ? pready1 : pready0;
  assign perr   = use_ws ? perr1 : perr0;
  assign prdata = use_ws ? prdata1 : prdata0;

  apb_timer #(.WAIT_STATES(0)) dut0 (
    .APB_PCLK(clk), .APB_PRESETn(rst_n), .APB_paddr(paddr), .APB_pdata(pdata),
    .APB_prdata(prdata0), .APB_psel(psel0), .APB_penable(penable),
    .APB_pwrite(pwrite), .APB_pstb(pstb), .APB_pready(pready0),
    .APB_perr(perr0), .interrupt(irq0)
  );

  apb_timer #(.WAIT_STATES(3)) dut1 (
    .APB_PCLK(clk), .APB_PRESETn(rst_n), .APB_paddr(paddr), .APB_pdata(pdata),
    .APB_prdata(prdata1), .APB_psel(psel1), .APB_penable(penable),
    .APB_pwrite(pwrite), .APB_pstb(pstb), .APB_pready(pready1),
    .APB_perr(perr1), .interrupt(irq1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit chk, input logic [31:0] exp_rd,
                      input bit exp_err, input string tag);
    exp_t e;
    int   lat;
    e.tag = tag; e.rdata = exp_rd; e.chk = chk & ~wr; e.err = exp_err;
    e.lat = use_ws ? 4 : 1;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = data; pstb = strb;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (pready !== 1'b1 && lat < 32) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({e.tag, "_rdy"}, pready, 1);
    check({e.tag, "_lat"}, lat, e.lat);
    check({e.tag, "_err"}, perr, e.err);
    if (e.chk) check({e.tag, "_rd"}, prdata, e.rdata);
    @(posedge clk);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    xfer(1'b0, addr, 32'h0, 4'h0, 1'b1, exp, 1'b0, tag);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input string tag);
    xfer(1'b1, addr, data, strb, 1'b0, 32'h0, 1'b0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pdata = 32'h0; pstb = 4'h0; use_ws = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pready", pready0, 0);
    check("rst_perr", perr0, 0);
    check("rst_prdata", prdata0, 0);
    check("rst_irq", irq0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    rd(B + 32'h00, 32'h0, "rst_mtlo");
    rd(B + 32'h04, 32'h0, "rst_mthi");
    rd(B + 32'h08, 32'hFFFF_FFFF, "rst_cmplo");
    rd(B + 32'h0C, 32'hFFFF_FFFF, "rst_cmphi");
    rd(B + 32'h10, 32'h0, "rst_ctrl");
    rd(B + 32'h14, 32'h0, "rst_status");

    // Compare match and interrupt timing
    wr(B + 32'h08, 32'd10, 4'hF, "w_cmplo");
    wr(B + 32'h0C, 32'd0, 4'hF, "w_cmphi");
    wr(B + 32'h10, 32'h3, 4'hF, "w_ctrl3");
    n = 0;
    while (irq0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise_lat", n, 12);
    rd(B + 32'h14, 32'h1, "status_set");
    wr(B + 32'h14, 32'h1, 4'hF, "clr_ge");
    @(negedge clk);
    check("irq_hold_ge", irq0, 1);
    rd(B + 32'h14, 32'h1, "status_hold");
    wr(B + 32'h0C, 32'h1, 4'hF, "w_cmphi1");
    wr(B + 32'h14, 32'h1, 4'hF, "clr_lt");
    @(negedge clk);
    check("irq_clr_lt", irq0, 0);
    rd(B + 32'h14, 32'h0, "status_clr");

    // Prescale 3 and 64-bit wrap
    wr(B + 32'h10, 32'h0, 4'hF, "w_ctrl0");
    wr(B + 32'h00, 32'hFFFF_FFFF, 4'hF, "w_mtlo_ff");
    wr(B + 32'h04, 32'hFFFF_FFFF, 4'hF, "w_mthi_ff");
    wr(B + 32'h10, 32'h0301, 4'hF, "w_ctrl_psc3");
    rd(B + 32'h00, 32'hFFFF_FFFF, "psc_r1");
    rd(B + 32'h00, 32'hFFFF_FFFF, "psc_r2");
    rd(B + 32'h00, 32'h0, "psc_wrap_lo");
    rd(B + 32'h04, 32'h0, "psc_wrap_hi");
    rd(B + 32'h00, 32'h1, "psc_r5");
    rd(B + 32'h00, 32'h1, "psc_r6");
    rd(B + 32'h00, 32'h2, "psc_r7");

    // Byte strobes
    wr(B + 32'h10, 32'h0, 4'hF, "w_ctrl_stop");
    wr(B + 32'h04, 32'h0, 4'hF, "w_mthi0");
    wr(B + 32'h00, 32'h0, 4'hF, "w_mtlo0");
    wr(B + 32'h04, 32'hEEEE_EE05, 4'h1, "w_mthi_b0");
    rd(B + 32'h00, 32'h0, "strb_lo");
    rd(B + 32'h04, 32'h5, "strb_hi");
    wr(B + 32'h08, 32'hFFFF_FFFF, 4'hF, "w_cmplo_ff");
    wr(B + 32'h08, 32'hAABB_CCDD, 4'h6, "w_cmplo_b12");
    rd(B + 32'h08, 32'hFFBB_CCFF, "strb_cmplo");

    // Address errors
    xfer(1'b0, B + 32'h18, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "err_r18");
    xfer(1'b0, B + 32'h02, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "err_r02");
    xfer(1'b1, B + 32'h02, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b1, "err_w02");
    rd(B + 32'h00, 32'h0, "err_nochg_lo");
    rd(B + 32'h08, 32'hFFBB_CCFF, "err_nochg_cmp");

    // Three wait states, error and abort on the second instance
    use_ws = 1'b1;
    rd(B + 32'h08, 32'hFFFF_FFFF, "ws3_cmplo");
    xfer(1'b0, B + 32'h18, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "ws3_err");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B; pdata = 32'h1234; pstb = 4'hF;
    @(negedge clk);
    check("abort_rdy_early", pready1, 0);
    psel = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | pready1;
    end
    penable = 1'b0;
    check("abort_no_rdy", seen, 0);
    rd(B + 32'h00, 32'h0, "abort_nowrite");
    use_ws = 1'b0;

    // Coherent 64-bit read across a carry
    wr(B + 32'h10, 32'h0, 4'hF, "coh_stop");
    wr(B + 32'h04, 32'h0, 4'hF, "coh_hi");
    wr(B + 32'h00, 32'hFFFF_FFFE, 4'hF, "coh_lo");
    wr(B + 32'h10, 32'h1, 4'hF, "coh_run");
    rd(B + 32'h00, 32'hFFFF_FFFF, "coh_lo1");
    rd(B + 32'h04, 32'h0, "coh_hi1");
    rd(B + 32'h00, 32'h3, "coh_lo2");
    rd(B + 32'h04, 32'h1, "coh_hi2");

    // Asynchronous reset in the middle of a read
    wr(B + 32'h10, 32'h2, 4'hF, "w_ctrl_irq");
    @(negedge clk);
    check("pre_rst_irq", irq0, 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = B + 32'h10; pstb = 4'h0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("pre_rst_rdy", pready0, 1);
    check("pre_rst_rd", prdata0, 32'h2);
    rst_n = 1'b0;
    #1;
    check("arst_pready", pready0, 0);
    check("arst_perr", perr0, 0);
    check("arst_prdata", prdata0, 0);
    check("arst_irq", irq0, 0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd(B + 32'h08, 32'hFFFF_FFFF, "post_rst_cmplo");
    rd(B + 32'h10, 32'h0, "post_rst_ctrl");
    rd(B + 32'h14, 32'h0, "post_rst_status");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
